// File: rtl/cpu_arith_sequencer_if.sv
// Request/result handshake and arithmetic-unit register bus seen by the
// sequencer. The master side is the sequencer (the only initiator on the bus);
// the slave side is the decode logic plus the arithmetic unit.
interface cpu_arith_sequencer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  req_valid;
    logic                  req_ready;
    logic [DATA_WIDTH-1:0] req_op;
    logic [DATA_WIDTH-1:0] req_a;
    logic [DATA_WIDTH-1:0] req_b;
    logic                  req_unary;
    logic                  res_valid;
    logic                  res_ready;
    logic [DATA_WIDTH-1:0] res_data;
    logic                  busy;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wr_data;
    logic                  mem_wr;
    logic                  mem_rd;
    logic [DATA_WIDTH-1:0] mem_rd_data;

    modport master (
        input  req_valid, req_op, req_a, req_b, req_unary, res_ready, mem_rd_data,
        output req_ready, res_valid, res_data, busy,
               mem_addr, mem_wr_data, mem_wr, mem_rd
    );

    modport slave (
        output req_valid, req_op, req_a, req_b, req_unary, res_ready, mem_rd_data,
        input  req_ready, res_valid, res_data, busy,
               mem_addr, mem_wr_data, mem_wr, mem_rd
    );
endinterface

// File: rtl/cpu_arith_sequencer.sv
// Arithmetic request sequencer: turns one request into the fixed register-bus
// sequence ACC write, TMP1 write (skipped for unary ops), opcode write,
// strobe-free compute gap, ACC read, and hands the result back.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   IDLE     | ready for a request; operands latched on req_valid
//   WR_ACC   | write operand A to ACC
//   WR_TMP   | write operand B to TMP1 (binary ops only)
//   WR_ALU   | write opcode; loads the compute-gap counter
//   WAIT     | no strobes; the arithmetic unit computes in the first one
//   RD_ACC   | read strobe on ACC
//   CAPTURE  | registered read data arrives and is stored as the result
//   RESP     | result offered until res_ready
module cpu_arith_sequencer #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    ADDR_WIDTH  = 4,
    parameter int                    WAIT_CYCLES = 1,
    parameter logic [ADDR_WIDTH-1:0] ACC_ADDR    = ADDR_WIDTH'(1),
    parameter logic [ADDR_WIDTH-1:0] TMP1_ADDR   = ADDR_WIDTH'(2),
    parameter logic [ADDR_WIDTH-1:0] ALU_ADDR    = ADDR_WIDTH'(3)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    cpu_arith_sequencer_if.master  bus
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR_ACC  = 3'd1;
    localparam logic [2:0] S_WR_TMP  = 3'd2;
    localparam logic [2:0] S_WR_ALU  = 3'd3;
    localparam logic [2:0] S_WAIT    = 3'd4;
    localparam logic [2:0] S_RD_ACC  = 3'd5;
    localparam logic [2:0] S_CAPTURE = 3'd6;
    localparam logic [2:0] S_RESP    = 3'd7;

    logic [2:0]            state;
    logic [3:0]            wait_cnt;
    logic [DATA_WIDTH-1:0] op_q;
    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] b_q;
    logic                  unary_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wr_data_q;
    logic [DATA_WIDTH-1:0] res_data_q;

    // Sequencing: address/data registers are loaded on the edge that enters
    // the state using them, so they hold their value while no strobe is active.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            wait_cnt      <= '0;
            op_q          <= '0;
            a_q           <= '0;
            b_q           <= '0;
            unary_q       <= 1'b0;
            mem_addr_q    <= '0;
            mem_wr_data_q <= '0;
            res_data_q    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        op_q          <= bus.req_op;
                        a_q           <= bus.req_a;
                        b_q           <= bus.req_b;
                        unary_q       <= bus.req_unary;
                        mem_addr_q    <= ACC_ADDR;
                        mem_wr_data_q <= bus.req_a;
                        state         <= S_WR_ACC;
                    end
                end
                S_WR_ACC: begin
                    if (unary_q) begin
                        mem_addr_q    <= ALU_ADDR;
                        mem_wr_data_q <= op_q;
                        state         <= S_WR_ALU;
                    end else begin
                        mem_addr_q    <= TMP1_ADDR;
                        mem_wr_data_q <= b_q;
                        state         <= S_WR_TMP;
                    end
                end
                S_WR_TMP: begin
                    mem_addr_q    <= ALU_ADDR;
                    mem_wr_data_q <= op_q;
                    state         <= S_WR_ALU;
                end
                S_WR_ALU: begin
                    wait_cnt <= 4'(WAIT_CYCLES - 1);
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        mem_addr_q <= ACC_ADDR;
                        state      <= S_RD_ACC;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                S_RD_ACC: begin
                    state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    res_data_q <= bus.mem_rd_data;
                    state      <= S_RESP;
                end
                S_RESP: begin
                    if (bus.res_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Strobes and handshake flags decode the state register only.
    assign bus.mem_wr      = (state == S_WR_ACC) || (state == S_WR_TMP) || (state == S_WR_ALU);
    assign bus.mem_rd      = (state == S_RD_ACC);
    assign bus.req_ready   = (state == S_IDLE);
    assign bus.res_valid   = (state == S_RESP);
    assign bus.busy        = (state != S_IDLE);
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wr_data = mem_wr_data_q;
    assign bus.res_data    = res_data_q;
endmodule

// File: tb/tb_cpu_arith_sequencer.sv
// Bench for cpu_arith_sequencer: two instances (compute gap 1 and 3), each
// attached to a small behavioural arithmetic-unit model.
`timescale 1ns/1ps
module tb_cpu_arith_sequencer;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam logic [AW-1:0] ACC_A = 4'h1;
    localparam logic [AW-1:0] TMP_A = 4'h2;
    localparam logic [AW-1:0] ALU_A = 4'h3;
    localparam logic [DW-1:0] OP_ADD  = 8'h01;
    localparam logic [DW-1:0] OP_SUB  = 8'h02;
    localparam logic [DW-1:0] OP_AND  = 8'h03;
    localparam logic [DW-1:0] OP_PLUS = 8'h04;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cpu_arith_sequencer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus0 ();
    cpu_arith_sequencer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();

    cpu_arith_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WAIT_CYCLES(1),
        .ACC_ADDR(ACC_A), .TMP1_ADDR(TMP_A), .ALU_ADDR(ALU_A))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    cpu_arith_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WAIT_CYCLES(3),
        .ACC_ADDR(ACC_A), .TMP1_ADDR(TMP_A), .ALU_ADDR(ALU_A))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    int errors = 0;
    int checks = 0;

    function automatic logic [DW-1:0] arith(input logic [DW-1:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_PLUS: return a + 8'd1;
            default: return a;
        endcase
    endfunction

    // Arithmetic unit: computes only in the cycle right after an opcode write,
    // and only if that cycle carries no write; read data is registered.
    logic [DW-1:0] acc0 = '0, tmp0 = '0, opr0 = '0;
    logic [DW-1:0] acc1 = '0, tmp1 = '0, opr1 = '0;
    logic pend0 = 1'b0, pend1 = 1'b0;
    initial begin
        bus0.mem_rd_data = '0;
        bus1.mem_rd_data = '0;
    end
    always @(posedge clk) begin
        if (bus0.mem_wr) begin
            if (bus0.mem_addr == ACC_A) acc0 <= bus0.mem_wr_data;
            if (bus0.mem_addr == TMP_A) tmp0 <= bus0.mem_wr_data;
            if (bus0.mem_addr == ALU_A) opr0 <= bus0.mem_wr_data;
            pend0 <= (bus0.mem_addr == ALU_A);
        end else begin
            if (pend0) acc0 <= arith(opr0, acc0, tmp0);
            pend0 <= 1'b0;
        end
        if (bus0.mem_rd) bus0.mem_rd_data <= acc0;
    end
    always @(posedge clk) begin
        if (bus1.mem_wr) begin
            if (bus1.mem_addr == ACC_A) acc1 <= bus1.mem_wr_data;
            if (bus1.mem_addr == TMP_A) tmp1 <= bus1.mem_wr_data;
            if (bus1.mem_addr == ALU_A) opr1 <= bus1.mem_wr_data;
            pend1 <= (bus1.mem_addr == ALU_A);
        end else begin
            if (pend1) acc1 <= arith(opr1, acc1, tmp1);
            pend1 <= 1'b0;
        end
        if (bus1.mem_rd) bus1.mem_rd_data <= acc1;
    end

    // Write and read strobes must never coincide on either bus.
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            assert (!(bus0.mem_wr && bus0.mem_rd) && !(bus1.mem_wr && bus1.mem_rd))
            else begin
                errors++;
                $display("FAIL strobe_overlap: got wr0=%0b rd0=%0b wr1=%0b rd1=%0b required never both high",
                         bus0.mem_wr, bus0.mem_rd, bus1.mem_wr, bus1.mem_rd);
            end
        end
    end

    typedef struct packed {
        logic          req_ready;
        logic          res_valid;
        logic          busy;
        logic          mem_wr;
        logic          mem_rd;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] res_data;
    } smp_t;

    typedef struct {
        int            sel;
        int            wc;
        logic [DW-1:0] op;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic          un;
        logic [DW-1:0] exp_res;
        string         name;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic smp_t sample(input int sel);
        smp_t s;
        if (sel == 0)
            s = {bus0.req_ready, bus0.res_valid, bus0.busy, bus0.mem_wr, bus0.mem_rd,
                 bus0.mem_addr, bus0.mem_wr_data, bus0.res_data};
        else
            s = {bus1.req_ready, bus1.res_valid, bus1.busy, bus1.mem_wr, bus1.mem_rd,
                 bus1.mem_addr, bus1.mem_wr_data, bus1.res_data};
        return s;
    endfunction

    task automatic drive(input int sel, input logic v, input logic [DW-1:0] op, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic un, input logic rr);
        if (sel == 0) begin
            bus0.req_valid = v; bus0.req_op = op; bus0.req_a = a;
            bus0.req_b = b; bus0.req_unary = un; bus0.res_ready = rr;
        end else begin
            bus1.req_valid = v; bus1.req_op = op; bus1.req_a = a;
            bus1.req_b = b; bus1.req_unary = un; bus1.res_ready = rr;
        end
    endtask

    // One request with res_ready high, checked cycle by cycle against the
    // expected bus timeline; conflicting requests are presented while busy.
    task automatic do_vec(input vec_t v);
        smp_t s;
        int n;
        logic ewr, erd, erv;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic [31:0] act, exp;
        s = sample(v.sel);
        check({v.name, " req_ready_c0"}, 32'(s.req_ready), 32'd1);
        drive(v.sel, 1'b1, v.op, v.a, v.b, v.un, 1'b1);
        tick();
        drive(v.sel, 1'b1, ~v.op, ~v.a, ~v.b, ~v.un, 1'b1);
        n = v.un ? (2 + v.wc + 3) : (3 + v.wc + 3);
        for (int c = 1; c <= n; c++) begin
            ewr = 1'b0; erd = 1'b0; erv = 1'b0; ea = '0; ed = '0;
            if (c == 1) begin ewr = 1'b1; ea = ACC_A; ed = v.a; end
            else if (!v.un && c == 2) begin ewr = 1'b1; ea = TMP_A; ed = v.b; end
            else if (c == (v.un ? 2 : 3)) begin ewr = 1'b1; ea = ALU_A; ed = v.op; end
            else if (c == n - 2) begin erd = 1'b1; ea = ACC_A; end
            else if (c == n) erv = 1'b1;
            s = sample(v.sel);
            act = {16'h0, s.busy, s.mem_wr, s.mem_rd, s.res_valid,
                   ((s.mem_wr | s.mem_rd) ? s.addr : {AW{1'b0}}), (s.mem_wr ? s.wdata : {DW{1'b0}})};
            exp = {16'h0, 1'b1, ewr, erd, erv, ea, ed};
            check($sformatf("%s bus_c%0d", v.name, c), act, exp);
            if (c == n) check({v.name, " res_data"}, 32'(s.res_data), 32'(v.exp_res));
            tick();
        end
        drive(v.sel, 1'b0, '0, '0, '0, 1'b0, 1'b1);
        s = sample(v.sel);
        check({v.name, " ready_after"}, {30'h0, s.req_ready, s.busy}, 32'h2);
    endtask

    vec_t vecs[8];
    smp_t s;
    smp_t rst_exp;
    int   w;
    logic bad;
    logic [DW-1:0] q[$];
    logic [DW-1:0] exp_d;
    logic pv, pun, rr;
    logic [DW-1:0] pop, pa, pb;
    int sent, got;

    initial begin
        vecs[0] = '{0, 1, OP_ADD,  8'h12, 8'h34, 1'b0, 8'h46, "add_12_34"};
        vecs[1] = '{0, 1, OP_PLUS, 8'hFF, 8'h99, 1'b1, 8'h00, "plus_ff_wrap"};
        vecs[2] = '{0, 1, OP_SUB,  8'h10, 8'h01, 1'b0, 8'h0F, "sub_10_01"};
        vecs[3] = '{0, 1, OP_AND,  8'hC5, 8'h3C, 1'b0, 8'h04, "and_c5_3c"};
        vecs[4] = '{0, 1, OP_ADD,  8'hFF, 8'h02, 1'b0, 8'h01, "add_wrap"};
        vecs[5] = '{1, 3, OP_SUB,  8'h10, 8'h01, 1'b0, 8'h0F, "w3_sub_10_01"};
        vecs[6] = '{1, 3, OP_PLUS, 8'h7F, 8'h00, 1'b1, 8'h80, "w3_plus_7f"};
        vecs[7] = '{0, 1, 8'hA7,   8'h5A, 8'h11, 1'b0, 8'h5A, "opaque_op"};

        drive(0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
        drive(1, 1'b0, '0, '0, '0, 1'b0, 1'b0);
        rst_exp = '0;
        rst_exp.req_ready = 1'b1;
        tick();
        tick();
        check("reset_dut0", 32'(sample(0)), 32'(rst_exp));
        check("reset_dut1", 32'(sample(1)), 32'(rst_exp));
        rst_n = 1'b1;
        tick();

        foreach (vecs[i]) do_vec(vecs[i]);

        // Result stall: held five cycles, new request ignored meanwhile.
        drive(0, 1'b1, OP_ADD, 8'h20, 8'h03, 1'b0, 1'b0);
        tick();
        drive(0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
        w = 0;
        while (!bus0.res_valid && w < 20) begin tick(); w++; end
        check("stall res_valid_cycle", 32'(w + 1), 32'd7);
        for (int k = 0; k < 5; k++) begin
            drive(0, 1'b1, OP_SUB, 8'hAA, 8'h55, 1'b0, 1'b0);
            s = sample(0);
            check($sformatf("stall hold%0d", k), {22'h0, s.res_valid, s.req_ready, s.res_data},
                  {22'h0, 1'b1, 1'b0, 8'h23});
            tick();
        end
        drive(0, 1'b0, '0, '0, '0, 1'b0, 1'b1);
        s = sample(0);
        check("stall still_valid", {23'h0, s.res_valid, s.res_data}, {23'h0, 1'b1, 8'h23});
        tick();
        s = sample(0);
        check("stall released", {30'h0, s.req_ready, s.busy}, 32'h2);

        // Reset pulse during the compute gap.
        drive(0, 1'b1, OP_ADD, 8'h11, 8'h22, 1'b0, 1'b1);
        tick();
        drive(0, 1'b0, '0, '0, '0, 1'b0, 1'b1);
        tick(); tick(); tick();
        s = sample(0);
        check("rst_mid in_wait", {29'h0, s.busy, s.mem_wr, s.mem_rd}, 32'h4);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid async", 32'(sample(0)), 32'(rst_exp));
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        bad = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (bus0.res_valid || bus0.busy) bad = 1'b1;
            tick();
        end
        check("rst_mid no_result", 32'(bad), 32'd0);
        do_vec('{0, 1, OP_AND, 8'h05, 8'h03, 1'b0, 8'h01, "after_rst_and"});

        // Random back-to-back traffic with random result stalls.
        sent = 0; got = 0; pv = 1'b1;
        pun = ($urandom_range(0, 3) == 0);
        pop = pun ? OP_PLUS : OP_ADD + 8'($urandom_range(0, 2));
        pa = 8'($urandom); pb = 8'($urandom);
        for (int cyc = 0; cyc < 3000 && got < 40; cyc++) begin
            s = sample(0);
            rr = ($urandom_range(0, 2) != 0);
            drive(0, pv, pop, pa, pb, pun, rr);
            if (s.res_valid && rr) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rand unexpected_result: got 0x%0h required no result", s.res_data);
                end else begin
                    exp_d = q.pop_front();
                    check($sformatf("rand res%0d", got), 32'(s.res_data), 32'(exp_d));
                end
                got++;
            end
            if (pv && s.req_ready) begin
                q.push_back(arith(pop, pa, pun ? 8'h00 : pb));
                sent++;
                pv = (sent < 40);
                pun = ($urandom_range(0, 3) == 0);
                pop = pun ? OP_PLUS : OP_ADD + 8'($urandom_range(0, 2));
                pa = 8'($urandom); pb = 8'($urandom);
            end
            tick();
        end
        check("rand result_count", 32'(got), 32'd40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/cpu_arith_sequencer.md
# cpu_arith_sequencer

Bus initiator that drives the arithmetic unit's register port (MEM_ADDR / MEM_WR / MEM_RD / MEM_WR_DATA / MEM_RD_DATA). It accepts one arithmetic request per handshake and runs a fixed bus sequence: load ACC, load TMP1, write the ALU opcode, wait for the compute cycle, then read ACC back. It returns the result on a valid/ready channel. It sits between the instruction decode logic and the arithmetic unit, and is the only master on that port.

## Interface
- WAIT_CYCLES, 1: idle bus cycles after the ALU opcode write and before the ACC read; legal range 1..15.
- ACC_ADDR, `ACC: arithmetic unit address of ACC.
- TMP1_ADDR, `TMP1_: address of TMP1.
- ALU_ADDR, `ALU_: address of the ALU opcode register.
- CLK  in  1  clock; the design uses a single clock.
- RST_N  in  1  reset, asynchronous assert, active-low.
- REQ_VALID  in  1  request present.
- REQ_READY  out  1  sequencer can accept a request.
- REQ_OP  in  `CPU_DATA_WIDTH  opcode written to ALU_ADDR (`ARITH_* encodings).
- REQ_A  in  `CPU_DATA_WIDTH  operand loaded into ACC.
- REQ_B  in  `CPU_DATA_WIDTH  operand loaded into TMP1.
- REQ_UNARY  in  1  when 1, the TMP1 write is skipped.
- RES_VALID  out  1  result available.
- RES_READY  in  1  consumer accepts the result.
- RES_DATA  out  `CPU_DATA_WIDTH  ACC value read back.
- BUSY  out  1  high in every state except IDLE.
- MEM_ADDR  out  `CPU_ADDR_WIDTH  bus address.
- MEM_WR_DATA  out  `CPU_DATA_WIDTH  bus write data.
- MEM_WR  out  1  write strobe.
- MEM_RD  out  1  read strobe.
- MEM_RD_DATA  in  `CPU_DATA_WIDTH  registered read data; valid one cycle after MEM_RD.

## Operation
- States: IDLE, WR_ACC, WR_TMP, WR_ALU, WAIT, RD_ACC, CAPTURE, RESP.
- IDLE: REQ_READY=1. On REQ_VALID, latch REQ_OP, REQ_A, REQ_B and REQ_UNARY, then go to WR_ACC.
- WR_ACC: MEM_WR=1, MEM_ADDR=ACC_ADDR, MEM_WR_DATA=A. Next state is WR_TMP, or WR_ALU if unary.
- WR_TMP: MEM_WR=1, MEM_ADDR=TMP1_ADDR, MEM_WR_DATA=B. Next state is WR_ALU.
- WR_ALU: MEM_WR=1, MEM_ADDR=ALU_ADDR, MEM_WR_DATA=OP. Load the wait counter with WAIT_CYCLES-1, then go to WAIT.
- WAIT: MEM_WR=0 and MEM_RD=0. This is mandatory: the arithmetic unit computes only in the cycle after the opcode write, and only if no write occurs in that cycle. The counter decrements each cycle; at 0, go to RD_ACC.
- RD_ACC: MEM_RD=1, MEM_ADDR=ACC_ADDR. Next state is CAPTURE.
- CAPTURE: no strobes. Register MEM_RD_DATA into RES_DATA, then go to RESP.
- RESP: RES_VALID=1. RES_DATA is held stable until RES_READY=1, then go to IDLE.
- MEM_WR and MEM_RD are never high in the same cycle. All bus outputs and handshake outputs are registered or decoded from the state register only; there is no combinational path from REQ_* or RES_READY to the bus.
- MEM_ADDR and MEM_WR_DATA hold their last value when no strobe is active.
- Opcode contents are not interpreted; any value is passed through.
- Reset values: state IDLE, REQ_READY=1, RES_VALID=0, BUSY=0, MEM_WR=0, MEM_RD=0, MEM_ADDR=0, MEM_WR_DATA=0, RES_DATA=0.

## Timing
- Cycle numbering: the request handshake completes in cycle 0.
- Binary operation:
  - Cycle 1: WR_ACC.
  - Cycle 2: WR_TMP.
  - Cycle 3: WR_ALU.
  - Cycles 4..3+WAIT_CYCLES: WAIT.
  - Next cycle: RD_ACC.
  - Next cycle: CAPTURE.
  - RES_VALID rises in the following cycle. With the default WAIT_CYCLES=1, RES_VALID is high in cycle 7.
- Unary operation: one cycle shorter. RES_VALID is high in cycle 6 with the default.
- RES_READY already high when RES_VALID rises: the result is accepted in one cycle and REQ_READY is high in the next cycle.
- Minimum request-to-request spacing is 8 cycles (default, binary).
- REQ_VALID while BUSY: ignored. REQ_READY=0, nothing is latched, and no bus activity is disturbed.
- RES_READY while not in RESP: ignored.
- Reset asserted mid-sequence, including during WAIT or RD_ACC: all outputs take their reset values immediately. The in-flight result is discarded. After RST_N deasserts, the first request starts a fresh, complete sequence; there is no partial replay.
- Back-to-back requests: the latched operands are never updated outside IDLE.

## Test plan
- Binary ADD, A=0x12, B=0x34, OP=`ARITH_ADD, against a behavioral arithmetic-unit model -> bus writes ACC=0x12, TMP1=0x34, ALU=OP in cycles 1-3; no strobe in cycle 4; MEM_RD in cycle 5; RES_DATA=0x46 with RES_VALID in cycle 7.
- Unary `ARITH_PLUS, A=0xFF -> no TMP1 write; RES_DATA=0x00 (8-bit wrap) in cycle 6.
- RES_READY held low for 5 cycles after RES_VALID -> RES_VALID and RES_DATA stable, REQ_READY=0 throughout; a new REQ_VALID during that window is not accepted.
- WAIT_CYCLES=3, `ARITH_SUB, A=0x10, B=0x01 -> three strobe-free cycles after the ALU write; RES_DATA=0x0F in cycle 9.
- RST_N pulsed low during WAIT -> strobes drop asynchronously, RES_VALID never asserts; the next request (A=0x05, B=0x03, `ARITH_AND) yields 0x01.
- Random back-to-back binary and unary requests with random RES_READY stalls -> assertion that MEM_WR and MEM_RD are never both high, and that every result matches the model.
